// File: rtl/lut_fgen_pkg.sv
// Shared types and helpers for the reconfigurable LUT function generator.
package lut_fgen_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } lut_state_e;

  function automatic int unsigned depth(input int unsigned sel_w);
    return 32'd1 << sel_w;
  endfunction

endpackage

// File: rtl/lut_fgen_cfg.sv
// Serial table loader: RUN/LOAD FSM, minterm counter, shadow table and commit strobe.
module lut_fgen_cfg
  import lut_fgen_pkg::*;
#(
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned NUM_FN = 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   cfg_start,
  input  logic                                   cfg_valid,
  input  logic [NUM_FN-1:0]                      cfg_bit,
  output logic                                   cfg_ready,
  output logic                                   cfg_done,
  output logic [NUM_FN-1:0][depth(SEL_W)-1:0]    shadow
);

  localparam int unsigned DEPTH = depth(SEL_W);
  localparam int unsigned CNT_W = SEL_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  lut_state_e                          state_q, state_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic [NUM_FN-1:0][DEPTH-1:0]        shadow_q, shadow_d;
  logic                                ready_q, ready_d;
  logic                                done_q, done_d;

  // Next-state: restart wins over a coincident beat; the final beat schedules the commit pulse.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    done_d   = 1'b0;
    case (state_q)
      RUN: begin
        if (cfg_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (cfg_start) begin
          cnt_d = '0;
        end else if (cfg_valid) begin
          for (int unsigned f = 0; f < NUM_FN; f++) begin
            shadow_d[f][cnt_q[SEL_W-1:0]] = cfg_bit[f];
          end
          if (cnt_q == LAST) begin
            state_d = RUN;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
    endcase
    ready_d = (state_d == LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      shadow_q <= '0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  assign cfg_ready = ready_q;
  assign cfg_done  = done_q;
  assign shadow    = shadow_q;

endmodule

// File: rtl/lut_mux_fgen.sv
// Reconfigurable Boolean function generator: active minterm tables feeding a registered mux per output.
module lut_mux_fgen
  import lut_fgen_pkg::*;
#(
  parameter int unsigned               SEL_W      = 3,
  parameter int unsigned               NUM_FN     = 1,
  parameter logic [depth(SEL_W)-1:0]   RESET_MASK = 'h96
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [SEL_W-1:0]    sel,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  input  logic [NUM_FN-1:0]   cfg_bit,
  output logic                cfg_ready,
  output logic                cfg_done,
  output logic [NUM_FN-1:0]   fn_out
);

  localparam int unsigned DEPTH = depth(SEL_W);

  logic [NUM_FN-1:0][DEPTH-1:0] shadow;
  logic [NUM_FN-1:0][DEPTH-1:0] active_q, active_d;
  logic [NUM_FN-1:0]            fn_out_q, fn_out_d;

  lut_fgen_cfg #(
    .SEL_W  (SEL_W),
    .NUM_FN (NUM_FN)
  ) u_cfg (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_ready (cfg_ready),
    .cfg_done  (cfg_done),
    .shadow    (shadow)
  );

  // The mux reads the pre-commit table, so the commit edge still outputs old values.
  always_comb begin
    active_d = active_q;
    if (cfg_done) begin
      active_d = shadow;
    end
    for (int unsigned f = 0; f < NUM_FN; f++) begin
      fn_out_d[f] = en ? active_q[f][sel] : 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= {NUM_FN{RESET_MASK}};
      fn_out_q <= '0;
    end else begin
      active_q <= active_d;
      fn_out_q <= fn_out_d;
    end
  end

  assign fn_out = fn_out_q;

endmodule

// File: tb/tb_lut_mux_fgen.sv
// Directed bench for lut_mux_fgen: default 3-input instance plus a 4-input, 2-function instance.
module tb_lut_mux_fgen;

  logic       clk;
  logic       rst_n;

  logic       en, cfg_start, cfg_valid, cfg_ready, cfg_done;
  logic [2:0] sel;
  logic [0:0] cfg_bit, fn_out;

  logic       en2, cfg_start2, cfg_valid2, cfg_ready2, cfg_done2;
  logic [3:0] sel2;
  logic [1:0] cfg_bit2, fn_out2;

  int n_checks;
  int n_pass;

  lut_mux_fgen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .sel       (sel),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_ready (cfg_ready),
    .cfg_done  (cfg_done),
    .fn_out    (fn_out)
  );

  lut_mux_fgen #(
    .SEL_W      (4),
    .NUM_FN     (2),
    .RESET_MASK (16'h0096)
  ) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en2),
    .sel       (sel2),
    .cfg_start (cfg_start2),
    .cfg_valid (cfg_valid2),
    .cfg_bit   (cfg_bit2),
    .cfg_ready (cfg_ready2),
    .cfg_done  (cfg_done2),
    .fn_out    (fn_out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  rm;
    logic [7:0]  maj;
    logic [15:0] m0;
    logic [15:0] m1;
    logic [1:0]  exp2;

    rm  = 8'h96;
    maj = 8'hE8;
    m0  = 16'h6996;
    m1  = 16'h8000;
    n_checks = 0;
    n_pass   = 0;

    rst_n = 1'b0;
    en = 1'b1; sel = 3'd7; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = '0;
    en2 = 1'b0; sel2 = '0; cfg_start2 = 1'b0; cfg_valid2 = 1'b0; cfg_bit2 = '0;

    // Reset state
    repeat (2) tick();
    check("rst_fn_out", 32'(fn_out), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd0);
    check("rst_done", 32'(cfg_done), 32'd0);
    rst_n = 1'b1;

    // 1: reset table 0x96
    sel = 3'b001; tick(); check("t1_sel1", 32'(fn_out), 32'(rm[1]));
    sel = 3'b011; tick(); check("t1_sel3", 32'(fn_out), 32'd0);
    sel = 3'b111; tick(); check("t1_sel7", 32'(fn_out), 32'd1);

    // 2: enable gating
    en = 1'b0; sel = 3'b111; tick(); check("t2_en0_s7", 32'(fn_out), 32'd0);
    sel = 3'b010; tick(); check("t2_en0_s2", 32'(fn_out), 32'd0);
    en = 1'b1; tick(); check("t2_en1_s2", 32'(fn_out), 32'd1);

    // 3: load majority with 2-cycle valid gaps; old table drives output meanwhile
    sel = 3'b001;
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    check("t3_ready", 32'(cfg_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      cfg_valid = 1'b1; cfg_bit = maj[i]; tick(); cfg_valid = 1'b0;
      if (i < 7) begin
        check("t3_done_early", 32'(cfg_done), 32'd0);
        repeat (2) tick();
        check("t3_old_during_load", 32'(fn_out), 32'd1);
      end
    end
    check("t3_done", 32'(cfg_done), 32'd1);
    tick();
    check("t3_done_pulse", 32'(cfg_done), 32'd0);
    check("t3_commit_edge_old", 32'(fn_out), 32'd1);
    check("t3_ready_after", 32'(cfg_ready), 32'd0);
    tick(); check("t3_new_sel1", 32'(fn_out), 32'd0);
    sel = 3'b011; tick(); check("t3_new_sel3", 32'(fn_out), 32'd1);

    // 4: restart after 4 beats (coincident beat discarded), then load all ones
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cfg_valid = 1'b1; cfg_bit = 1'b0; tick();
    end
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_bit = 1'b0; tick(); cfg_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cfg_valid = 1'b1; cfg_bit = 1'b1; tick();
      if (i == 3) check("t4_no_done_at_4", 32'(cfg_done), 32'd0);
    end
    cfg_valid = 1'b0;
    check("t4_done", 32'(cfg_done), 32'd1);
    repeat (2) tick();
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s); tick(); check("t4_all_ones", 32'(fn_out), 32'd1);
    end

    // 5: reset in the middle of a load
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cfg_valid = 1'b1; cfg_bit = 1'b0; tick();
    end
    cfg_valid = 1'b0;
    rst_n = 1'b0; #1;
    check("t5_ready_rst", 32'(cfg_ready), 32'd0);
    check("t5_fn_rst", 32'(fn_out), 32'd0);
    tick(); rst_n = 1'b1;
    sel = 3'b111; tick(); check("t5_mask_s7", 32'(fn_out), 32'd1);
    sel = 3'b011; tick(); check("t5_mask_s3", 32'(fn_out), 32'd0);
    check("t5_ready_idle", 32'(cfg_ready), 32'd0);

    // 6: two 4-input functions (parity, AND)
    en2 = 1'b1; sel2 = 4'd15;
    cfg_start2 = 1'b1; tick(); cfg_start2 = 1'b0;
    check("t6_ready", 32'(cfg_ready2), 32'd1);
    for (int i = 0; i < 16; i++) begin
      cfg_valid2 = 1'b1; cfg_bit2 = {m1[i], m0[i]}; tick();
    end
    cfg_valid2 = 1'b0;
    check("t6_done", 32'(cfg_done2), 32'd1);
    tick();
    check("t6_commit_edge_old", 32'(fn_out2), 32'd0);
    tick();
    check("t6_new_s15", 32'(fn_out2), 32'd2);
    for (int s = 0; s < 16; s++) begin
      sel2 = 4'(s);
      exp2 = {(s == 15) ? 1'b1 : 1'b0, ^(4'(s))};
      tick(); check("t6_sweep", 32'(fn_out2), 32'(exp2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
